controller_fsm_mc: RTL and testbench
====================================

Name: controller_fsm_mc

Overview:
- Multi-cycle, parametrised successor to the single-cycle accumulator-CPU controller.
- Sequences FETCH / LOAD / DECODE / EXEC per instruction.
- Handshakes instruction fetch with program memory (MemReq/MemReady) and adds a fetch timeout with trap.
- Adds illegal-opcode trap, HALT with resume, and a retired-instruction counter.
- Drives the same datapath control set (IR, PC, Reg, Acc, ALU select).

Parameters:
- OPW, 4, opcode width; SelALU width equals OPW.
- TMO, 16, max FETCH cycles waiting for MemReady before trap (≥1).
- CNTW, 16, width of InstrCount.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLB  in  1  reset, synchronous, active-high.
- MemReady  in  1  program memory has instruction word valid.
- Opcode  in  OPW  IR opcode field, valid from DECODE onward.
- Z  in  1  accumulator-zero flag.
- C  in  1  carry/negative flag.
- Resume  in  1  leave HALT.
- MemReq  out  1  instruction fetch request.
- LoadIR  out  1  IR load strobe.
- IncPC  out  1  PC <= PC+1.
- SelPC  out  1  PC source: 1 = immediate, 0 = register.
- LoadPC  out  1  PC <= selected source.
- LoadReg  out  1  Reg <= Acc.
- LoadAcc  out  1  Acc load strobe.
- SelAcc  out  2  Acc source: 00 = imm, 01 = ALU, 10 = reg.
- SelALU  out  OPW  ALU operation select.
- Trap  out  1  one-cycle fault pulse.
- Halted  out  1  high while in HALT.
- InstrCount  out  CNTW  retired instructions.

Behaviour:
Outputs and reset:
- All outputs are registered.
- CLB high at a clock edge: state <= FETCH; every output <= 0; timeout counter <= 0; InstrCount <= 0. This applies from any state, including mid-fetch and HALT.

FETCH:
- MemReq = 1.
- MemReady sampled high -> LOAD; MemReq drops.
- Otherwise the counter increments. If MemReady is still low on the TMO-th consecutive cycle -> Trap pulse, then HALT.
- Counter clears on leaving FETCH.

LOAD:
- LoadIR = 1 for exactly this one cycle -> DECODE.

DECODE:
- Latch Opcode, Z and C; no strobes -> EXEC.
- Z/C changes after DECODE are ignored for the current instruction.

EXEC (one cycle; strobes high for exactly this cycle):
- SelALU = latched opcode.
- InstrCount += 1 on every EXEC, wrapping modulo 2^CNTW.
- Next state is FETCH unless noted below.
- In each row below, every strobe not listed is 0.

EXEC decode (opcode values for OPW=4; wider OPW zero-extends these codes, all others illegal):
- 0001 add, 0010 sub, 0011 nor, 1011 shl, 1100 shr: LoadAcc=1, SelAcc=01, IncPC=1.
- 0100 reg->acc: LoadAcc=1, SelAcc=10, IncPC=1.
- 1101 imm->acc: LoadAcc=1, SelAcc=00, IncPC=1.
- 0101 acc->reg: LoadReg=1, IncPC=1.
- 0110 JZ reg, 0111 JZ imm: taken when latched Z=1.
- 1000 JC reg, 1010 JC imm: taken when latched C=1.
- Jump taken: LoadPC=1, IncPC=0, SelPC=1 for imm forms, 0 for reg forms.
- Jump not taken: IncPC=1.
- 0000 NOP: IncPC=1.
- 1111 HALT: IncPC=0, no strobes -> HALT. It is counted as retired.
- Illegal (1001, 1110, others): no strobes, Trap=1, not counted -> HALT.

HALT:
- Halted = 1; all strobes 0; MemReq 0.
- Resume sampled high -> FETCH, Halted drops next cycle.
- Resume has no effect outside HALT.
- PC is not advanced on resume: after a HALT opcode, software jumps or the host advances PC; the HALT instruction is not re-executed only if PC was changed externally.

Simultaneous events:
- CLB beats everything.
- Timeout and MemReady on the same edge: MemReady wins, no trap.

Latency:
- 4 cycles per instruction with MemReady high on the first FETCH cycle.
- Each MemReady-low cycle adds one.

Test Plan:
- Reset: CLB high 2 cycles with MemReady=1 -> all outputs 0. First cycle after release: MemReq=1. LoadIR on cycle 2. Strobes on cycle 4. InstrCount=1 after the 0001 add (LoadAcc=1, SelAcc=01, SelALU=0001, IncPC=1).
- Fetch wait: MemReady low 3 cycles then high, TMO=16 -> MemReq high 4 cycles, no Trap. MemReady never high -> Trap pulse on FETCH cycle 16, then Halted=1.
- Branches: 0111 with Z=1 latched -> LoadPC=1, SelPC=1, IncPC=0. With Z=0 -> IncPC=1, LoadPC=0. Z toggled after DECODE has no effect. 1000 with C=1 -> LoadPC=1, SelPC=0.
- HALT/resume: 1111 -> Halted=1, InstrCount incremented, strobes 0 for 10 cycles. Resume pulse -> MemReq=1 the next cycle.
- Illegal 1001 -> Trap=1 one cycle, no strobes, InstrCount unchanged, Halted=1.
- Reset mid-operation: CLB asserted during DECODE -> FETCH, InstrCount=0, no EXEC strobes emitted. Wrap check with CNTW=4: 16 NOPs -> InstrCount=0.

Source files
------------

// File: rtl/controller_fsm_mc_if.sv
// Datapath/program-memory side signals of the multi-cycle accumulator-CPU controller.
// The controller takes the master view; the memory/datapath model takes the slave view.
interface controller_fsm_mc_if #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
);
    logic            MemReady;
    logic [OPW-1:0]  Opcode;
    logic            Z;
    logic            C;
    logic            Resume;

    logic            MemReq;
    logic            LoadIR;
    logic            IncPC;
    logic            SelPC;
    logic            LoadPC;
    logic            LoadReg;
    logic            LoadAcc;
    logic [1:0]      SelAcc;
    logic [OPW-1:0]  SelALU;
    logic            Trap;
    logic            Halted;
    logic [CNTW-1:0] InstrCount;

    modport master (
        input  MemReady, Opcode, Z, C, Resume,
        output MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
               SelAcc, SelALU, Trap, Halted, InstrCount
    );

    modport slave (
        output MemReady, Opcode, Z, C, Resume,
        input  MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
               SelAcc, SelALU, Trap, Halted, InstrCount
    );
endinterface

// File: rtl/controller_fsm_mc.sv
// Multi-cycle FETCH/LOAD/DECODE/EXEC controller with fetch timeout, illegal-opcode trap,
// HALT/resume and a retired-instruction counter. Every output comes straight from a register.
module controller_fsm_mc #(
    parameter int OPW  = 4,
    parameter int TMO  = 16,
    parameter int CNTW = 16
) (
    input  logic                CLK,
    input  logic                CLB,
    controller_fsm_mc_if.master bus
);
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_TRAP,
        S_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              exec_halt_reg, exec_halt_next;
    logic              mem_req_reg, mem_req_next;
    logic              load_ir_reg, load_ir_next;
    logic              inc_pc_reg, inc_pc_next;
    logic              sel_pc_reg, sel_pc_next;
    logic              load_pc_reg, load_pc_next;
    logic              load_reg_reg, load_reg_next;
    logic              load_acc_reg, load_acc_next;
    logic [1:0]        sel_acc_reg, sel_acc_next;
    logic [OPW-1:0]    sel_alu_reg, sel_alu_next;
    logic              trap_reg, trap_next;
    logic              halted_reg, halted_next;
    logic [CNTW-1:0]   count_reg, count_next;
    logic              legal;

    // Outputs are computed for the state being entered, so they are valid for the whole
    // cycle spent in that state. DECODE->EXEC is where Opcode, Z and C are sampled.
    always_comb begin
        state_next     = state_reg;
        tmo_next       = '0;
        exec_halt_next = 1'b0;
        mem_req_next   = 1'b0;
        load_ir_next   = 1'b0;
        inc_pc_next    = 1'b0;
        sel_pc_next    = 1'b0;
        load_pc_next   = 1'b0;
        load_reg_next  = 1'b0;
        load_acc_next  = 1'b0;
        sel_acc_next   = 2'b00;
        sel_alu_next   = '0;
        trap_next      = 1'b0;
        halted_next    = 1'b0;
        count_next     = count_reg;
        legal          = 1'b1;

        case (state_reg)
            S_FETCH: begin
                if (!mem_req_reg) begin
                    // First cycle out of reset: raise the request before sampling MemReady.
                    mem_req_next = 1'b1;
                end else if (bus.MemReady) begin
                    state_next   = S_LOAD;
                    load_ir_next = 1'b1;
                end else if (tmo_reg == TMO_W'(TMO - 1)) begin
                    state_next = S_TRAP;
                    trap_next  = 1'b1;
                end else begin
                    mem_req_next = 1'b1;
                    tmo_next     = tmo_reg + 1'b1;
                end
            end

            S_LOAD: begin
                state_next = S_DECODE;
            end

            S_DECODE: begin
                state_next   = S_EXEC;
                sel_alu_next = bus.Opcode;
                case (bus.Opcode)
                    OPW'(4'h1), OPW'(4'h2), OPW'(4'h3), OPW'(4'hB), OPW'(4'hC): begin
                        load_acc_next = 1'b1;
                        sel_acc_next  = 2'b01;
                        inc_pc_next   = 1'b1;
                    end
                    OPW'(4'h4): begin
                        load_acc_next = 1'b1;
                        sel_acc_next  = 2'b10;
                        inc_pc_next   = 1'b1;
                    end
                    OPW'(4'hD): begin
                        load_acc_next = 1'b1;
                        inc_pc_next   = 1'b1;
                    end
                    OPW'(4'h5): begin
                        load_reg_next = 1'b1;
                        inc_pc_next   = 1'b1;
                    end
                    OPW'(4'h6), OPW'(4'h7): begin
                        load_pc_next = bus.Z;
                        sel_pc_next  = bus.Z && (bus.Opcode == OPW'(4'h7));
                        inc_pc_next  = !bus.Z;
                    end
                    OPW'(4'h8), OPW'(4'hA): begin
                        load_pc_next = bus.C;
                        sel_pc_next  = bus.C && (bus.Opcode == OPW'(4'hA));
                        inc_pc_next  = !bus.C;
                    end
                    OPW'(4'h0): begin
                        inc_pc_next = 1'b1;
                    end
                    OPW'(4'hF): begin
                        exec_halt_next = 1'b1;
                    end
                    default: begin
                        legal          = 1'b0;
                        trap_next      = 1'b1;
                        exec_halt_next = 1'b1;
                    end
                endcase
                if (legal) begin
                    count_next = count_reg + 1'b1;
                end
            end

            S_EXEC: begin
                if (exec_halt_reg) begin
                    state_next  = S_HALT;
                    halted_next = 1'b1;
                end else begin
                    state_next   = S_FETCH;
                    mem_req_next = 1'b1;
                end
            end

            S_TRAP: begin
                state_next  = S_HALT;
                halted_next = 1'b1;
            end

            S_HALT: begin
                if (bus.Resume) begin
                    state_next   = S_FETCH;
                    mem_req_next = 1'b1;
                end else begin
                    halted_next = 1'b1;
                end
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLB) begin
            state_reg     <= S_FETCH;
            tmo_reg       <= '0;
            exec_halt_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
            load_ir_reg   <= 1'b0;
            inc_pc_reg    <= 1'b0;
            sel_pc_reg    <= 1'b0;
            load_pc_reg   <= 1'b0;
            load_reg_reg  <= 1'b0;
            load_acc_reg  <= 1'b0;
            sel_acc_reg   <= 2'b00;
            sel_alu_reg   <= '0;
            trap_reg      <= 1'b0;
            halted_reg    <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            tmo_reg       <= tmo_next;
            exec_halt_reg <= exec_halt_next;
            mem_req_reg   <= mem_req_next;
            load_ir_reg   <= load_ir_next;
            inc_pc_reg    <= inc_pc_next;
            sel_pc_reg    <= sel_pc_next;
            load_pc_reg   <= load_pc_next;
            load_reg_reg  <= load_reg_next;
            load_acc_reg  <= load_acc_next;
            sel_acc_reg   <= sel_acc_next;
            sel_alu_reg   <= sel_alu_next;
            trap_reg      <= trap_next;
            halted_reg    <= halted_next;
            count_reg     <= count_next;
        end
    end

    assign bus.MemReq     = mem_req_reg;
    assign bus.LoadIR     = load_ir_reg;
    assign bus.IncPC      = inc_pc_reg;
    assign bus.SelPC      = sel_pc_reg;
    assign bus.LoadPC     = load_pc_reg;
    assign bus.LoadReg    = load_reg_reg;
    assign bus.LoadAcc    = load_acc_reg;
    assign bus.SelAcc     = sel_acc_reg;
    assign bus.SelALU     = sel_alu_reg;
    assign bus.Trap       = trap_reg;
    assign bus.Halted     = halted_reg;
    assign bus.InstrCount = count_reg;
endmodule

// File: tb/tb_controller_fsm_mc.sv
// Directed bench for controller_fsm_mc: instruction-level model emits per-cycle expectations,
// checked against a CNTW=16 and a CNTW=4 instance driven with identical inputs.
module tb_controller_fsm_mc;
    localparam int TMO = 16;

    typedef struct packed {
        logic       mem_req;
        logic       load_ir;
        logic       inc_pc;
        logic       sel_pc;
        logic       load_pc;
        logic       load_reg;
        logic       load_acc;
        logic [1:0] sel_acc;
        logic [3:0] sel_alu;
        logic       trap;
        logic       halted;
        logic [15:0] count;
    } vec_t;

    logic        clk;
    logic        clb;
    logic        mem_ready;
    logic [3:0]  opcode;
    logic        z_in;
    logic        c_in;
    logic        resume;
    logic [15:0] cnt;
    vec_t        exp_q[$];
    int          cmp_n, cmp_f, lit_n, lit_f, cyc;
    int          mreq_seen, trap_seen;
    int          m0, t0;

    controller_fsm_mc_if #(.OPW(4), .CNTW(16)) bus_a ();
    controller_fsm_mc_if #(.OPW(4), .CNTW(4))  bus_b ();

    assign bus_a.MemReady = mem_ready;
    assign bus_a.Opcode   = opcode;
    assign bus_a.Z        = z_in;
    assign bus_a.C        = c_in;
    assign bus_a.Resume   = resume;
    assign bus_b.MemReady = mem_ready;
    assign bus_b.Opcode   = opcode;
    assign bus_b.Z        = z_in;
    assign bus_b.C        = c_in;
    assign bus_b.Resume   = resume;

    controller_fsm_mc #(.OPW(4), .TMO(TMO), .CNTW(16)) dut_a (
        .CLK (clk),
        .CLB (clb),
        .bus (bus_a)
    );

    controller_fsm_mc #(.OPW(4), .TMO(TMO), .CNTW(4)) dut_b (
        .CLK (clk),
        .CLB (clb),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Compare process: one expectation per checked cycle, sampled mid-cycle.
    always @(negedge clk) begin
        vec_t e, eb, va, vb;
        cyc++;
        va = {bus_a.MemReq, bus_a.LoadIR, bus_a.IncPC, bus_a.SelPC, bus_a.LoadPC,
              bus_a.LoadReg, bus_a.LoadAcc, bus_a.SelAcc, bus_a.SelALU, bus_a.Trap,
              bus_a.Halted, bus_a.InstrCount};
        vb = {bus_b.MemReq, bus_b.LoadIR, bus_b.IncPC, bus_b.SelPC, bus_b.LoadPC,
              bus_b.LoadReg, bus_b.LoadAcc, bus_b.SelAcc, bus_b.SelALU, bus_b.Trap,
              bus_b.Halted, 12'd0, bus_b.InstrCount};
        if (bus_a.MemReq === 1'b1) mreq_seen++;
        if (bus_a.Trap === 1'b1) trap_seen++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eb = e;
            eb.count = {12'd0, e.count[3:0]};
            cmp_n++;
            if (va !== e) begin
                cmp_f++;
                $display("FAIL cycle_cnt16 at cycle %0d: got %h expected %h", cyc, va, e);
            end
            cmp_n++;
            if (vb !== eb) begin
                cmp_f++;
                $display("FAIL cycle_cnt4 at cycle %0d: got %h expected %h", cyc, vb, eb);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        lit_n++;
        if (act !== req) begin
            lit_f++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t base();
        vec_t v;
        v = '0;
        v.count = cnt;
        return v;
    endfunction

    // Inputs for the current cycle are already driven; queue its expectation and advance.
    task automatic step(input vec_t e, input bit chk);
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one executed opcode with the flags seen at DECODE.
    task automatic exec_exp(input logic [3:0] op, input bit z, input bit c,
                            output vec_t v, output bit stop);
        bit legal = 1'b1;
        bit taken;
        stop = 1'b0;
        v = '0;
        v.sel_alu = op;
        case (op)
            4'h1, 4'h2, 4'h3, 4'hB, 4'hC: begin v.load_acc = 1; v.sel_acc = 2'b01; v.inc_pc = 1; end
            4'h4: begin v.load_acc = 1; v.sel_acc = 2'b10; v.inc_pc = 1; end
            4'hD: begin v.load_acc = 1; v.sel_acc = 2'b00; v.inc_pc = 1; end
            4'h5: begin v.load_reg = 1; v.inc_pc = 1; end
            4'h6, 4'h7, 4'h8, 4'hA: begin
                taken = (op == 4'h6 || op == 4'h7) ? z : c;
                if (taken) begin
                    v.load_pc = 1;
                    v.sel_pc  = (op == 4'h7 || op == 4'hA);
                end else begin
                    v.inc_pc = 1;
                end
            end
            4'h0: v.inc_pc = 1;
            4'hF: stop = 1'b1;
            default: begin legal = 1'b0; v.trap = 1; stop = 1'b1; end
        endcase
        if (legal) cnt = cnt + 16'd1;
        v.count = cnt;
    endtask

    task automatic reset_seq(input int n);
        clb = 1; mem_ready = 1; resume = 0;
        step(base(), 1'b0);
        cnt = '0;
        for (int i = 1; i < n; i++) step(base(), 1'b1);
        clb = 0;
        step(base(), 1'b1);
    endtask

    task automatic halt_phase(input int hc);
        vec_t v;
        v = base();
        v.halted = 1;
        mem_ready = 1; resume = 0;
        for (int i = 0; i < hc; i++) step(v, 1'b1);
        resume = 1;
        step(v, 1'b1);
        resume = 0;
    endtask

    // One instruction: `waits` MemReady-low cycles, then LOAD/DECODE/EXEC; flags and
    // opcode carry wrong values outside DECODE so mis-timed sampling shows up.
    task automatic instr(input logic [3:0] op, input bit z, input bit c,
                         input int waits, input int hc);
        vec_t v;
        bit stop;
        resume = 0; opcode = ~op; z_in = ~z; c_in = ~c;
        v = base();
        v.mem_req = 1;
        mem_ready = 0;
        for (int i = 0; i < waits && i < TMO; i++) step(v, 1'b1);
        if (waits >= TMO) begin
            v = base();
            v.trap = 1;
            step(v, 1'b1);
            halt_phase(hc);
            return;
        end
        mem_ready = 1;
        step(v, 1'b1);
        v = base();
        v.load_ir = 1;
        mem_ready = 0; resume = 1;
        step(v, 1'b1);
        resume = 0; mem_ready = 1; opcode = op; z_in = z; c_in = c;
        step(base(), 1'b1);
        exec_exp(op, z, c, v, stop);
        z_in = ~z; c_in = ~c; resume = 1;
        step(v, 1'b1);
        resume = 0;
        if (stop) halt_phase(hc);
    endtask

    task automatic abort_at_decode(input logic [3:0] op);
        vec_t v;
        v = base();
        v.mem_req = 1;
        mem_ready = 1; opcode = ~op;
        step(v, 1'b1);
        v = base();
        v.load_ir = 1;
        mem_ready = 0;
        step(v, 1'b1);
        opcode = op; clb = 1;
        step(base(), 1'b1);
        cnt = '0; clb = 0;
        step(base(), 1'b1);
    endtask

    initial begin
        clk = 0; clb = 1; mem_ready = 1; opcode = '0; z_in = 0; c_in = 0; resume = 0;
        cnt = '0; cmp_n = 0; cmp_f = 0; lit_n = 0; lit_f = 0; cyc = 0;
        mreq_seen = 0; trap_seen = 0;

        reset_seq(2);
        lit("post_reset_memreq", 32'(bus_a.MemReq), 32'd1);
        lit("post_reset_count", 32'(bus_a.InstrCount), 32'd0);

        instr(4'h1, 0, 0, 0, 0);
        lit("add_count", 32'(bus_a.InstrCount), 32'd1);
        instr(4'h3, 1, 1, 0, 0);
        instr(4'h4, 0, 1, 0, 0);
        instr(4'hD, 1, 0, 0, 0);
        instr(4'h5, 0, 0, 0, 0);
        instr(4'hB, 1, 1, 0, 0);
        instr(4'hC, 0, 0, 0, 0);
        instr(4'h2, 1, 0, 0, 0);

        m0 = mreq_seen;
        instr(4'h0, 0, 0, 3, 0);
        lit("wait3_memreq_cycles", 32'(mreq_seen - m0), 32'd4);
        t0 = trap_seen;
        instr(4'h0, 0, 0, TMO - 1, 0);
        lit("wait15_no_trap", 32'(trap_seen - t0), 32'd0);

        instr(4'h7, 1, 0, 0, 0);
        instr(4'h7, 0, 1, 0, 0);
        instr(4'h6, 1, 0, 0, 0);
        instr(4'h8, 0, 1, 0, 0);
        instr(4'h8, 1, 0, 0, 0);
        instr(4'hA, 0, 1, 0, 0);
        lit("branch_count", 32'(bus_a.InstrCount), 32'd16);

        instr(4'hF, 0, 0, 0, 10);
        lit("halt_count", 32'(bus_a.InstrCount), 32'd17);
        lit("resume_memreq", 32'(bus_a.MemReq), 32'd1);

        instr(4'h9, 0, 0, 0, 3);
        instr(4'hE, 1, 1, 0, 1);
        lit("illegal_count", 32'(bus_a.InstrCount), 32'd17);

        m0 = mreq_seen;
        t0 = trap_seen;
        instr(4'h0, 0, 0, TMO, 2);
        lit("timeout_memreq_cycles", 32'(mreq_seen - m0), 32'd16);
        lit("timeout_trap_pulses", 32'(trap_seen - t0), 32'd1);

        abort_at_decode(4'h1);
        lit("abort_count", 32'(bus_a.InstrCount), 32'd0);
        lit("abort_memreq", 32'(bus_a.MemReq), 32'd1);

        for (int i = 0; i < 16; i++) instr(4'h0, 0, 0, 0, 0);
        lit("nop16_count16", 32'(bus_a.InstrCount), 32'd16);
        lit("nop16_count4_wrap", 32'(bus_b.InstrCount), 32'd0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_n + lit_n, cmp_f + lit_f);
        $finish;
    end
endmodule
